dispatch_queue: RTL and testbench
=================================

// Module: dispatch_queue
// PURPOSE
//  Parametrised N-wide in-order instruction buffer between fetch and the issue stage.
//  Accepts up to FETCH_WIDTH IF_ID_PACKETs per cycle.
//  Presents up to ISSUE_WIDTH oldest entries per cycle to the decode/issue lanes,
//  throttled by ROB and RS free-slot counts.
//  Adds flush-on-mispredict and WFI halt-drain behaviour.
//  Replaces the single-slot rob_full/rs_full stall with credit-based multi-slot dispatch.
// PARAMETERS
//  FETCH_WIDTH   2    packets accepted per cycle (lanes 0..FW-1)
//  ISSUE_WIDTH   2    packets dispatched per cycle (lanes 0..IW-1)
//  DEPTH         8    queue entries; power of 2, >= FETCH_WIDTH+ISSUE_WIDTH
//  CNT_W  $clog2(DEPTH+1)  occupancy/credit width (derived, not overridable)
// PORTS
//  clock           in   1             system clock
//  reset           in   1             synchronous, active-high
//  flush           in   1             mispredict/exception squash
//  in_packet       in   FW x IF_ID_PACKET  fetch group; .valid per lane
//  in_ready        out  1             queue can take a full group this cycle
//  rob_free        in   CNT_W         free ROB slots this cycle
//  rs_free         in   CNT_W         free RS slots this cycle
//  out_packet      out  IW x IF_ID_PACKET  oldest entries; .valid = dispatched
//  out_count       out  $clog2(IW+1)  number of lanes dispatched this cycle
//  count           out  CNT_W         current occupancy
//  halted          out  1             WFI dispatched; dispatch frozen
// BEHAVIOUR
//  Reset (synchronous, active-high):
//   - count=0, head=tail=0, halted=0.
//   - All out_packet[i].valid=0, out_count=0, in_ready=1.
//  Input side:
//   - Valid lanes must be contiguous from lane 0.
//   - in_ready = (DEPTH-count) >= FW, computed from registered count.
//   - Accept all-or-nothing: when in_ready && !flush, every valid lane is written
//     at tail in lane order; tail advances by the number of valid lanes.
//   - When !in_ready, the group is dropped; fetch must hold it.
//  Dispatch side:
//   - n = min(count, IW, rob_free, rs_free), further truncated as described below.
//   - out_packet[i] = entry[head+i] for i<n with .valid=1; lanes i>=n drive .valid=0.
//   - head advances by n at the clock edge.
//   - Outputs are combinational from the queue registers and credit inputs.
//   - An entry written in cycle T is dispatchable no earlier than T+1 (no bypass).
//  Halt:
//   - The first WFI entry at position k truncates n to k+1; the WFI dispatches
//     as the last lane.
//   - halted sets on the following edge.
//   - While halted, n=0 and in_ready=0.
//   - Only reset or flush clears halted.
//  Simultaneous accept and dispatch: count_next = count + accepted - n.
//   - in_ready uses the pre-dispatch count, so DEPTH is never exceeded.
//  Flush:
//   - Next edge: count=0, head=tail=0, halted=0.
//   - The input group in the flush cycle is discarded.
//   - Dispatch in the flush cycle is suppressed: out_count=0, all .valid=0.
//   - flush && reset behaves as reset.
//  Wrap-around: head and tail are log2(DEPTH) bits and wrap mod DEPTH;
//   lane index arithmetic (head+i) wraps identically.
//  Credits larger than IW are clamped; rob_free=0 or rs_free=0 gives n=0.
// TESTING
//  1. Reset, then 4 groups of 2 valid packets, rob_free=rs_free=0
//     -> count=8, in_ready=0 after the 4th group, 5th group dropped, out_count=0.
//  2. Full queue, rob_free=1, rs_free=5
//     -> out_count=1 per cycle; PCs leave in fetch order; in_ready=1 once count<=6.
//  3. Concurrent steady state: 2 in/2 out per cycle for 20 cycles, DEPTH=8
//     -> count constant; head/tail wrap at least twice; PC sequence in order.
//  4. WFI in lane 0 with an ADD behind it, credits=2
//     -> out_count=1 (WFI); halted=1 next cycle; ADD never dispatched.
//  5. flush asserted with count=5 and a valid input group
//     -> next cycle count=0, halted=0, in_ready=1, flush-cycle outputs invalid.
//  6. Input lanes {valid, invalid}, credits=2
//     -> tail advances by 1; next cycle out_count=1.

Source files
------------

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order circular buffer between fetch and issue.
// Takes up to FETCH_WIDTH packets per cycle, all-or-nothing. Presents up to
// ISSUE_WIDTH of its oldest entries, limited by ROB/RS credits. A dispatched WFI
// freezes the queue until flush or reset.

package dispatch_queue_pkg;

  // Fetch-to-decode packet. valid qualifies the lane; pc/inst are the payload.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_packet_t;

  // RISC-V WFI encoding.
  localparam logic [31:0] WFI_INST = 32'h1050_0073;

  function automatic logic is_wfi(input if_id_packet_t p);
    return p.inst == WFI_INST;
  endfunction

endpackage

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter  int FETCH_WIDTH = 2,
  parameter  int ISSUE_WIDTH = 2,
  parameter  int DEPTH       = 8,
  localparam int CNT_W       = $clog2(DEPTH + 1),
  localparam int OCNT_W      = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  if_id_packet_t [FETCH_WIDTH-1:0]  in_packet,
  output logic                             in_ready,
  input  logic [CNT_W-1:0]                 rob_free,
  input  logic [CNT_W-1:0]                 rs_free,
  output if_id_packet_t [ISSUE_WIDTH-1:0]  out_packet,
  output logic [OCNT_W-1:0]                out_count,
  output logic [CNT_W-1:0]                 count,
  output logic                             halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ACC_W = $clog2(FETCH_WIDTH + 1);

  // Queue storage and bookkeeping state.
  if_id_packet_t      entry_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               halted_q, halted_d;

  // Combinational intermediates.
  logic [CNT_W-1:0]   credit;
  logic [OCNT_W-1:0]  disp_n;
  logic               wfi_sent;
  logic [ACC_W-1:0]   acc_n;
  logic               accept;
  logic               run;

  // Dispatch width: min(count, IW, rob_free, rs_free), then cut after the first WFI.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    credit   = count_q;
    disp_n   = '0;
    wfi_sent = 1'b0;
    if (rob_free < credit)             credit = rob_free;
    if (rs_free < credit)              credit = rs_free;
    if (CNT_W'(ISSUE_WIDTH) < credit)  credit = CNT_W'(ISSUE_WIDTH);
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      out_packet[i]       = entry_q[head_q + PTR_W'(i)];
      out_packet[i].valid = 1'b0;
      if (!halted_q && !flush && !wfi_sent && (CNT_W'(i) < credit)) begin
        out_packet[i].valid = 1'b1;
        disp_n              = OCNT_W'(i + 1);
        if (is_wfi(out_packet[i])) wfi_sent = 1'b1;
      end
    end
  end

  // Input side: room for a full group from the registered count; count contiguous valid lanes.
  always_comb begin
    in_ready = !halted_q && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH));
    accept   = in_ready && !flush;
    acc_n    = '0;
    run      = 1'b1;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (run && in_packet[i].valid) acc_n = ACC_W'(i + 1);
      else                           run   = 1'b0;
    end
    if (!accept) acc_n = '0;
  end

  // Next-state pointers, occupancy and halt flag; flush clears everything.
  always_comb begin
    head_d   = head_q + PTR_W'(disp_n);
    tail_d   = tail_q + PTR_W'(acc_n);
    count_d  = count_q + CNT_W'(acc_n) - CNT_W'(disp_n);
    halted_d = halted_q | wfi_sent;
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Write accepted lanes at tail in lane order.
  always_ff @(posedge clock) begin
    // NOTE: storage is left unreset; only valid entries are ever presented, and count gates that.
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (ACC_W'(i) < acc_n) entry_q[tail_q + PTR_W'(i)] <= in_packet[i];
    end
  end

  assign out_count = disp_n;
  assign count     = count_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.

module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int FW     = 2;
  localparam int IW     = 2;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int OCNT_W = $clog2(IW + 1);
  localparam logic [31:0] ADD = 32'h0020_81b3;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     flush = 1'b0;
  if_id_packet_t [FW-1:0]   in_packet = '0;
  logic                     in_ready;
  logic [CNT_W-1:0]         rob_free = '0;
  logic [CNT_W-1:0]         rs_free = '0;
  if_id_packet_t [IW-1:0]   out_packet;
  logic [OCNT_W-1:0]        out_count;
  logic [CNT_W-1:0]         count;
  logic                     halted;

  int errors = 0;
  int checks = 0;
  logic [31:0] pc_next = 32'h1000;

  dispatch_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clock(clk), .reset(reset), .flush(flush), .in_packet(in_packet),
    .in_ready(in_ready), .rob_free(rob_free), .rs_free(rs_free),
    .out_packet(out_packet), .out_count(out_count), .count(count), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: the queue contents in age order plus the halt flag.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t mq[$];
  bit   m_halted = 0;

  // Compare outputs against the model mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    int  n;
    bit  exp_ready;
    bit  wfi_out;
    n = mq.size();
    if (n > IW) n = IW;
    if (int'(rob_free) < n) n = int'(rob_free);
    if (int'(rs_free) < n) n = int'(rs_free);
    for (int k = 0; k < n; k++) begin
      if (mq[k].inst == WFI_INST) begin
        n = k + 1;
        break;
      end
    end
    if (m_halted || flush) n = 0;
    exp_ready = !m_halted && ((DEPTH - mq.size()) >= FW);

    if (!reset) begin
      check("count", 64'(count), 64'(mq.size()));
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("halted", 64'(halted), 64'(m_halted));
      check("out_count", 64'(out_count), 64'(n));
      for (int k = 0; k < IW; k++) begin
        check($sformatf("lane%0d.valid", k), 64'(out_packet[k].valid), 64'(k < n));
        if (k < n) begin
          check($sformatf("lane%0d.pc", k), 64'(out_packet[k].pc), 64'(mq[k].pc));
          check($sformatf("lane%0d.inst", k), 64'(out_packet[k].inst), 64'(mq[k].inst));
        end
      end
    end

    if (reset || flush) begin
      mq.delete();
      m_halted = 0;
    end else begin
      wfi_out = 0;
      for (int k = 0; k < n; k++) begin
        if (mq[0].inst == WFI_INST) wfi_out = 1;
        void'(mq.pop_front());
      end
      if (wfi_out) m_halted = 1;
      if (exp_ready) begin
        for (int k = 0; k < FW; k++) begin
          if (!in_packet[k].valid) break;
          mq.push_back('{pc: in_packet[k].pc, inst: in_packet[k].inst});
        end
      end
    end
  end

  // Present a fetch group (contiguous valid lanes) plus credits and flush.
  task automatic drive(input int nv, input logic [31:0] i0, input logic [31:0] i1,
                       input int rob, input int rs, input bit fl);
    in_packet[0].valid = (nv > 0);
    in_packet[0].pc    = pc_next;
    in_packet[0].inst  = i0;
    in_packet[1].valid = (nv > 1);
    in_packet[1].pc    = pc_next + 32'd4;
    in_packet[1].inst  = i1;
    rob_free = CNT_W'(rob);
    rs_free  = CNT_W'(rs);
    flush    = fl;
  endtask

  // Advance one clock; fetch moves on only if the group was taken.
  task automatic tick();
    bit adv;
    int nv;
    #1;
    adv = in_ready && !flush && !reset;
    nv  = int'(in_packet[0].valid) + int'(in_packet[0].valid && in_packet[1].valid);
    @(posedge clk);
    #1;
    if (adv) pc_next += 32'(4 * nv);
  endtask

  initial begin
    // Reset
    drive(0, ADD, ADD, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    drive(0, ADD, ADD, 0, 0, 0);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_count", 64'(out_count), 64'd0);
    tick();

    // 1: fill with no credits, fifth group dropped
    for (int g = 0; g < 4; g++) begin
      drive(2, ADD, ADD, 0, 0, 0);
      tick();
    end
    drive(2, ADD, ADD, 0, 0, 0);
    #1;
    check("t1_count_full", 64'(count), 64'd8);
    check("t1_in_ready", 64'(in_ready), 64'd0);
    check("t1_out_count", 64'(out_count), 64'd0);
    tick();
    drive(0, ADD, ADD, 1, 5, 0);
    #1;
    check("t1_dropped", 64'(count), 64'd8);

    // 2: one credit from the ROB, in order drain
    check("t2_out_count", 64'(out_count), 64'd1);
    check("t2_first_pc", 64'(out_packet[0].pc), 64'h1000);
    for (int c = 0; c < 8; c++) begin
      drive(0, ADD, ADD, 1, 5, 0);
      tick();
    end
    check("t2_drained", 64'(count), 64'd0);

    // 3: steady state two in / two out with wrap-around
    drive(2, ADD, ADD, 0, 0, 0);
    tick();
    drive(2, ADD, ADD, 0, 0, 0);
    tick();
    for (int c = 0; c < 20; c++) begin
      drive(2, ADD, ADD, 2, 2, 0);
      tick();
    end
    check("t3_count_steady", 64'(count), 64'd4);
    drive(0, ADD, ADD, 2, 2, 0);
    tick();
    tick();

    // 4: WFI then ADD; only the WFI leaves and the queue halts
    drive(2, WFI_INST, ADD, 2, 2, 0);
    tick();
    drive(0, ADD, ADD, 2, 2, 0);
    #1;
    check("t4_out_count", 64'(out_count), 64'd1);
    check("t4_wfi_inst", 64'(out_packet[0].inst), 64'(WFI_INST));
    check("t4_lane1_idle", 64'(out_packet[1].valid), 64'd0);
    tick();
    #1;
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_halt_out", 64'(out_count), 64'd0);
    check("t4_halt_ready", 64'(in_ready), 64'd0);
    check("t4_add_kept", 64'(count), 64'd1);
    tick();
    tick();

    // 5: flush with five entries and a valid group
    drive(0, ADD, ADD, 2, 2, 1);
    tick();
    drive(2, ADD, ADD, 0, 0, 0);
    tick();
    tick();
    drive(1, ADD, ADD, 0, 0, 0);
    tick();
    drive(2, ADD, ADD, 2, 2, 1);
    #1;
    check("t5_pre_count", 64'(count), 64'd5);
    check("t5_flush_out", 64'(out_count), 64'd0);
    check("t5_flush_valid", 64'(out_packet[0].valid), 64'd0);
    tick();
    drive(0, ADD, ADD, 0, 0, 0);
    #1;
    check("t5_count", 64'(count), 64'd0);
    check("t5_halted", 64'(halted), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    tick();

    // 6: partial group {valid, invalid}
    drive(1, ADD, ADD, 2, 2, 0);
    tick();
    drive(0, ADD, ADD, 2, 2, 0);
    #1;
    check("t6_count", 64'(count), 64'd1);
    check("t6_out_count", 64'(out_count), 64'd1);
    tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      logic [31:0] i0, i1;
      i0 = ($urandom_range(0, 15) == 0) ? WFI_INST : $urandom;
      i1 = ($urandom_range(0, 15) == 0) ? WFI_INST : $urandom;
      reset = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 2), i0, i1, $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 24) == 0);
      tick();
    end
    reset = 1'b0;
    drive(0, ADD, ADD, 0, 0, 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
